// File: rtl/tdm_pkg.sv
// Shared TDM definitions: framing states, slot indices and counter operations.
// Used by both the transmit-side mux and the receive-side demux.
package tdm_pkg;

    typedef enum logic {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } tdm_state_t;

    typedef enum logic [1:0] {
        CTR_HOLD  = 2'd0,
        CTR_CLEAR = 2'd1,
        CTR_LOAD1 = 2'd2,
        CTR_INC   = 2'd3
    } ctr_op_t;

    localparam logic [1:0] SLOT_A = 2'd0;
    localparam logic [1:0] SLOT_B = 2'd1;
    localparam logic [1:0] SLOT_C = 2'd2;
    localparam logic [1:0] SLOT_D = 2'd3;

    localparam int NUM_SLOTS = 4;

endpackage

// File: rtl/tdm_slot_ctr.sv
// Two-bit TDM slot counter with clear, load-1, wrapping increment and hold.
module tdm_slot_ctr
    import tdm_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  ctr_op_t    op,
    output logic [1:0] slot
);

    always_ff @(posedge clk) begin
        if (reset) begin
            slot <= SLOT_A;
        end else begin
            unique case (op)
                CTR_CLEAR: slot <= SLOT_A;
                CTR_LOAD1: slot <= SLOT_B;
                CTR_INC:   slot <= slot + 2'd1;
                default:   slot <= slot;
            endcase
        end
    end

endmodule

// File: rtl/tdm_demux4.sv
// 1:4 TDM demux: stages slots 0..2, then publishes all four channels at frame end.
module tdm_demux4
    import tdm_pkg::*;
#(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic             frame_sync,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic [WIDTH-1:0] out_c,
    output logic [WIDTH-1:0] out_d,
    output logic             frame_valid,
    output logic             locked,
    output logic [1:0]       slot,
    output logic             sync_err
);

    tdm_state_t state;
    tdm_state_t next_state;
    ctr_op_t    op;

    logic [WIDTH-1:0] stage_a;
    logic [WIDTH-1:0] stage_b;
    logic [WIDTH-1:0] stage_c;

    logic cap_a;
    logic cap_b;
    logic cap_c;
    logic done;
    logic err;

    tdm_slot_ctr u_ctr (
        .clk   (clk),
        .reset (reset),
        .op    (op),
        .slot  (slot)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_HUNT;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        op         = CTR_HOLD;
        cap_a      = 1'b0;
        cap_b      = 1'b0;
        cap_c      = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        if (in_valid) begin
            unique case (state)
                ST_HUNT: begin
                    if (frame_sync) begin
                        cap_a      = 1'b1;
                        op         = CTR_LOAD1;
                        next_state = ST_LOCKED;
                    end
                end
                ST_LOCKED: begin
                    if (frame_sync) begin
                        // sync off slot 0 restarts the frame from this sample
                        cap_a = 1'b1;
                        op    = CTR_LOAD1;
                        err   = (slot != SLOT_A);
                    end else begin
                        unique case (slot)
                            SLOT_A: begin
                                err        = 1'b1;
                                op         = CTR_CLEAR;
                                next_state = ST_HUNT;
                            end
                            SLOT_B: begin
                                cap_b = 1'b1;
                                op    = CTR_INC;
                            end
                            SLOT_C: begin
                                cap_c = 1'b1;
                                op    = CTR_INC;
                            end
                            default: begin
                                done = 1'b1;
                                op   = CTR_INC;
                            end
                        endcase
                    end
                end
                default: next_state = ST_HUNT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stage_a     <= '0;
            stage_b     <= '0;
            stage_c     <= '0;
            out_a       <= '0;
            out_b       <= '0;
            out_c       <= '0;
            out_d       <= '0;
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            frame_valid <= done;
            sync_err    <= err;
            if (cap_a) stage_a <= in_data;
            if (cap_b) stage_b <= in_data;
            if (cap_c) stage_c <= in_data;
            if (done) begin
                out_a <= stage_a;
                out_b <= stage_b;
                out_c <= stage_c;
                out_d <= in_data;
            end
        end
    end

    assign locked = (state == ST_LOCKED);

endmodule

// File: tb/tb_tdm_demux4.sv
// Directed scoreboard bench for tdm_demux4, run at WIDTH=1 and WIDTH=8 in lockstep.
module tb_tdm_demux4;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] c;
        logic [7:0] d;
    } frame_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       frame_sync = 1'b0;

    logic [7:0] a8, b8, c8, d8;
    logic       fv8, lk8, err8;
    logic [1:0] slot8;
    logic       a1, b1, c1, d1;
    logic       fv1, lk1, err1;
    logic [1:0] slot1;

    int     total = 0;
    int     bad = 0;
    frame_t sb[$];
    frame_t hold;

    always #5 clk = ~clk;

    tdm_demux4 #(.WIDTH(8)) dut8 (
        .clk         (clk),
        .reset       (reset),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .frame_sync  (frame_sync),
        .out_a       (a8),
        .out_b       (b8),
        .out_c       (c8),
        .out_d       (d8),
        .frame_valid (fv8),
        .locked      (lk8),
        .slot        (slot8),
        .sync_err    (err8)
    );

    tdm_demux4 #(.WIDTH(1)) dut1 (
        .clk         (clk),
        .reset       (reset),
        .in_data     (in_data[0]),
        .in_valid    (in_valid),
        .frame_sync  (frame_sync),
        .out_a       (a1),
        .out_b       (b1),
        .out_c       (c1),
        .out_d       (d1),
        .frame_valid (fv1),
        .locked      (lk1),
        .slot        (slot1),
        .sync_err    (err1)
    );

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_outs();
        chk("a8", a8, hold.a);
        chk("b8", b8, hold.b);
        chk("c8", c8, hold.c);
        chk("d8", d8, hold.d);
        chk("abcd1", {4'b0, a1, b1, c1, d1},
            {4'b0, hold.a[0], hold.b[0], hold.c[0], hold.d[0]});
    endtask

    task automatic step(input logic v, input logic s, input logic [7:0] d,
                        input logic efv, input logic eerr,
                        input logic [1:0] eslot, input logic elock);
        in_valid   = v;
        frame_sync = s;
        in_data    = d;
        @(posedge clk);
        #1;
        chk("stat8", {3'b0, fv8, err8, slot8, lk8},
            {3'b0, efv, eerr, eslot, elock});
        chk("stat1", {3'b0, fv1, err1, slot1, lk1},
            {3'b0, efv, eerr, eslot, elock});
        if (fv8) begin
            chk("sb_hit", {7'b0, sb.size() != 0}, 8'd1);
            if (sb.size() != 0) hold = sb.pop_front();
        end
        chk_outs();
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        hold = '0;
        sb.delete();
        chk("rst8", {3'b0, fv8, err8, slot8, lk8}, 8'd0);
        chk("rst1", {3'b0, fv1, err1, slot1, lk1}, 8'd0);
        chk_outs();
        reset = 1'b0;
    endtask

    task automatic send_frame(input frame_t f);
        step(1'b1, 1'b1, f.a, 1'b0, 1'b0, 2'd1, 1'b1);
        step(1'b1, 1'b0, f.b, 1'b0, 1'b0, 2'd2, 1'b1);
        step(1'b1, 1'b0, f.c, 1'b0, 1'b0, 2'd3, 1'b1);
        sb.push_back(f);
        step(1'b1, 1'b0, f.d, 1'b1, 1'b0, 2'd0, 1'b1);
    endtask

    initial begin
        hold = '0;
        do_reset(2);
        for (int i = 0; i < 12; i++) begin
            in_valid   = 1'($urandom);
            frame_sync = 1'($urandom);
            in_data    = 8'($urandom);
            @(posedge clk);
        end
        do_reset(2);

        // clean frame: bit0 pattern 1,0,1,1
        send_frame('{8'hA5, 8'h3C, 8'h0F, 8'hC3});
        step(1'b0, 1'b0, 8'hFF, 1'b0, 1'b0, 2'd0, 1'b1);

        // gaps between slots 1 and 2, sync asserted while invalid
        step(1'b1, 1'b1, 8'h81, 1'b0, 1'b0, 2'd1, 1'b1);
        step(1'b1, 1'b0, 8'h42, 1'b0, 1'b0, 2'd2, 1'b1);
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 2'd2, 1'b1);
        step(1'b1, 1'b0, 8'h23, 1'b0, 1'b0, 2'd3, 1'b1);
        sb.push_back('{8'h81, 8'h42, 8'h23, 8'h15});
        step(1'b1, 1'b0, 8'h15, 1'b1, 1'b0, 2'd0, 1'b1);

        // back-to-back at full rate
        send_frame('{8'h12, 8'h34, 8'h56, 8'h78});
        send_frame('{8'h9A, 8'hBC, 8'hDE, 8'hF1});

        // early sync at slot 2
        step(1'b1, 1'b1, 8'h55, 1'b0, 1'b0, 2'd1, 1'b1);
        step(1'b1, 1'b0, 8'h66, 1'b0, 1'b0, 2'd2, 1'b1);
        step(1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 2'd1, 1'b1);
        step(1'b1, 1'b0, 8'h77, 1'b0, 1'b0, 2'd2, 1'b1);
        step(1'b1, 1'b0, 8'h88, 1'b0, 1'b0, 2'd3, 1'b1);
        sb.push_back('{8'h00, 8'h77, 8'h88, 8'h99});
        step(1'b1, 1'b0, 8'h99, 1'b1, 1'b0, 2'd0, 1'b1);

        // missing sync at slot 0, then non-sync samples dropped
        step(1'b1, 1'b0, 8'hEE, 1'b0, 1'b1, 2'd0, 1'b0);
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b0, 8'hE1, 1'b0, 1'b0, 2'd0, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 1'b0);

        // mid-frame reset after slot 2, slot-3 sample presented during reset
        step(1'b1, 1'b1, 8'h31, 1'b0, 1'b0, 2'd1, 1'b1);
        step(1'b1, 1'b0, 8'h32, 1'b0, 1'b0, 2'd2, 1'b1);
        step(1'b1, 1'b0, 8'h33, 1'b0, 1'b0, 2'd3, 1'b1);
        in_valid   = 1'b1;
        frame_sync = 1'b0;
        in_data    = 8'h34;
        do_reset(1);
        step(1'b1, 1'b0, 8'h34, 1'b0, 1'b0, 2'd0, 1'b0);

        // recovery
        send_frame('{8'hC6, 8'h5B, 8'h2E, 8'h71});
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 1'b1);

        chk("sb_empty", {7'b0, sb.size() == 0}, 8'd1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
